// File: rtl/sha256_pkg.sv
// Shared constants, byte-FSM state type and the length-field byte selector
// for the SHA-256 message padder.
package sha256_pkg;

  localparam int BLOCK_BYTES = 64;
  localparam int LEN_POS     = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    PAD  = 3'd2,
    ZERO = 3'd3,
    LEN  = 3'd4
  } byte_state_e;

  // sel=0 picks the most significant byte of the 64-bit bit length
  function automatic logic [7:0] len_byte(input logic [63:0] bit_len, input logic [2:0] sel);
    return bit_len[{3'(3'd7 - sel), 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sha256_word_packer.sv
// Packs a byte stream into registered 32-bit big-endian words with a
// per-block word index and block/message end flags.
module sha256_word_packer
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [7:0]  i_data,
  input  logic        i_last,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_word,
  output logic [3:0]  o_idx,
  output logic        o_blk_last,
  output logic        o_msg_last
);

  logic [23:0] r_acc;
  logic [1:0]  r_acc_cnt;
  logic [31:0] r_word;
  logic        r_valid;
  logic [3:0]  r_idx;
  logic [3:0]  r_next_idx;
  logic        r_blk_last;
  logic        r_msg_last;

  logic w_slot_free;
  logic w_fire;
  logic w_load;

  // The 4th byte may only land when the output register is empty or draining this cycle
  assign w_slot_free = !r_valid || i_ready;
  assign o_ready     = (r_acc_cnt != 2'd3) || w_slot_free;
  assign w_fire      = i_valid && o_ready;
  assign w_load      = w_fire && (r_acc_cnt == 2'd3);

  // Accumulator and output word register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc      <= 24'd0;
      r_acc_cnt  <= 2'd0;
      r_word     <= 32'd0;
      r_valid    <= 1'b0;
      r_idx      <= 4'd0;
      r_next_idx <= 4'd0;
      r_blk_last <= 1'b0;
      r_msg_last <= 1'b0;
    end else begin
      if (w_fire) begin
        if (r_acc_cnt == 2'd3) begin
          r_acc_cnt <= 2'd0;
        end else begin
          r_acc     <= {r_acc[15:0], i_data};
          r_acc_cnt <= r_acc_cnt + 2'd1;
        end
      end
      if (w_load) begin
        r_word     <= {r_acc, i_data};
        r_valid    <= 1'b1;
        r_idx      <= r_next_idx;
        r_blk_last <= (r_next_idx == 4'd15);
        r_msg_last <= i_last;
        r_next_idx <= r_next_idx + 4'd1;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_word     = r_word;
  assign o_idx      = r_idx;
  assign o_blk_last = r_blk_last;
  assign o_msg_last = r_msg_last;

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: passes message bytes, then appends 0x80, zero fill
// and the 64-bit bit length, handing bytes to the word packer.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int CNT_W = 61
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        in_empty,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [3:0]  out_idx,
  output logic        out_blk_last,
  output logic        out_msg_last
);

  byte_state_e      r_state;
  byte_state_e      w_state_nxt;
  logic [5:0]       r_bp;
  logic [CNT_W-1:0] r_cnt;
  logic             r_en;

  logic        w_byte_valid;
  logic [7:0]  w_byte_data;
  logic        w_byte_last;
  logic        w_pk_ready;
  logic        w_accept;
  logic        w_fire;
  logic [5:0]  w_bp_inc;
  logic [63:0] w_bit_len;

  // r_en keeps in_ready low for the first cycle out of reset
  assign in_ready  = r_en && ((r_state == IDLE) || (r_state == DATA)) && w_pk_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_fire    = w_byte_valid && w_pk_ready;
  assign w_bp_inc  = r_bp + 6'd1;
  assign w_bit_len = 64'({r_cnt, 3'b000});

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; bp wraps so a late PAD simply zero-fills through the next block
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DATA: begin
        if (w_accept) begin
          w_state_nxt = in_last ? PAD : DATA;
        end else begin
          w_state_nxt = r_state;
        end
      end
      PAD, ZERO: begin
        if (w_fire) begin
          w_state_nxt = (w_bp_inc == 6'(LEN_POS)) ? LEN : ZERO;
        end else begin
          w_state_nxt = r_state;
        end
      end
      LEN: begin
        if (w_fire && (r_bp == 6'd63)) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Byte source towards the packer
  always_comb begin
    w_byte_valid = 1'b0;
    w_byte_data  = 8'd0;
    w_byte_last  = 1'b0;
    case (r_state)
      IDLE, DATA: begin
        w_byte_valid = r_en && in_valid && !(in_last && in_empty);
        w_byte_data  = in_data;
      end
      PAD: begin
        w_byte_valid = 1'b1;
        w_byte_data  = PAD_BYTE;
      end
      ZERO: begin
        w_byte_valid = 1'b1;
        w_byte_data  = 8'd0;
      end
      LEN: begin
        w_byte_valid = 1'b1;
        w_byte_data  = len_byte(w_bit_len, r_bp[2:0]);
        w_byte_last  = (r_bp == 6'd63);
      end
      default: begin
        w_byte_valid = 1'b0;
      end
    endcase
  end

  // Byte counter, byte pointer and ready enable
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bp  <= 6'd0;
      r_cnt <= '0;
      r_en  <= 1'b0;
    end else begin
      r_en <= 1'b1;
      if (w_fire) begin
        r_bp <= w_bp_inc;
      end
      if ((r_state == IDLE) && w_accept) begin
        r_cnt <= w_fire ? CNT_W'(1) : '0;
      end else if ((r_state == DATA) && w_fire) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  sha256_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .i_valid    (w_byte_valid),
    .o_ready    (w_pk_ready),
    .i_data     (w_byte_data),
    .i_last     (w_byte_last),
    .o_valid    (out_valid),
    .i_ready    (out_ready),
    .o_word     (out_word),
    .o_idx      (out_idx),
    .o_blk_last (out_blk_last),
    .o_msg_last (out_msg_last)
  );

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: hand-computed spot words plus a
// padded-byte reference for every emitted word.
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_empty;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [3:0]  out_idx;
  logic        out_blk_last;
  logic        out_msg_last;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0]  msg [0:127];
  logic [31:0] got_w [$];
  logic [3:0]  got_i [$];
  logic        got_b [$];
  logic        got_m [$];

  always #5 clk = ~clk;

  sha256_msg_padder dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_empty     (in_empty),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_word     (out_word),
    .out_idx      (out_idx),
    .out_blk_last (out_blk_last),
    .out_msg_last (out_msg_last)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Streams msg[0..n-1] (or one empty terminating beat), collects words, compares to reference
  task automatic run_msg(input string tag, input int n, input bit emp,
                         input int st_start, input int st_len);
    int sent = 0;
    int cyc = 0;
    int nbeats;
    int after = 0;
    bit done = 1'b0;
    bit acc;
    bit stall;
    bit hold_ok = 1'b0;
    logic [31:0] hold = 32'd0;
    logic [7:0] eb [$];
    logic [63:0] bit_len;
    int ewords;
    got_w.delete(); got_i.delete(); got_b.delete(); got_m.delete();
    nbeats = emp ? 1 : n;
    while (!done && cyc < 3000) begin
      in_valid  = (sent < nbeats);
      in_data   = emp ? 8'd0 : msg[sent];
      in_last   = (sent == nbeats - 1);
      in_empty  = emp;
      stall     = (st_len > 0) && (cyc >= st_start) && (cyc < st_start + st_len);
      out_ready = !stall;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (stall) begin
        if (out_valid) begin
          if (!hold_ok) begin
            hold    = out_word;
            hold_ok = 1'b1;
          end else begin
            check({tag, " stall word stable"}, 64'(out_word), 64'(hold));
          end
          if (acc) after++;
        end
        if (cyc == st_start + st_len - 1) begin
          check({tag, " stall in_ready low"}, 64'(in_ready), 64'd0);
          check({tag, " stall bytes after word"}, 64'(after), 64'd3);
        end
      end
      if (out_valid && out_ready) begin
        got_w.push_back(out_word);
        got_i.push_back(out_idx);
        got_b.push_back(out_blk_last);
        got_m.push_back(out_msg_last);
        if (out_msg_last) done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0; out_ready = 1'b1;
    check({tag, " completed in budget"}, 64'(done), 64'd1);

    for (int i = 0; i < (emp ? 0 : n); i++) eb.push_back(msg[i]);
    eb.push_back(8'h80);
    while ((eb.size() % 64) != 56) eb.push_back(8'h00);
    bit_len = 64'(emp ? 0 : n) * 64'd8;
    for (int k = 7; k >= 0; k--) eb.push_back(bit_len[k*8 +: 8]);
    ewords = eb.size() / 4;
    check({tag, " word count"}, 64'(got_w.size()), 64'(ewords));
    for (int w = 0; w < ewords && w < got_w.size(); w++) begin
      check($sformatf("%s w%0d data", tag, w), 64'(got_w[w]),
            64'({eb[4*w], eb[4*w+1], eb[4*w+2], eb[4*w+3]}));
      check($sformatf("%s w%0d idx", tag, w), 64'(got_i[w]), 64'(w % 16));
      check($sformatf("%s w%0d blk_last", tag, w), 64'(got_b[w]), 64'((w % 16) == 15));
      check($sformatf("%s w%0d msg_last", tag, w), 64'(got_m[w]), 64'(w == ewords - 1));
    end
  endtask

  task automatic load_abc();
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0;
    in_empty = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset out_word", 64'(out_word), 64'd0);
    check("reset out_idx", 64'(out_idx), 64'd0);
    check("reset blk_last", 64'(out_blk_last), 64'd0);
    check("reset msg_last", 64'(out_msg_last), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("in_ready after reset", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    load_abc();
    run_msg("abc", 3, 1'b0, 0, 0);
    check("abc w0", 64'(got_w[0]), 64'h61626380);
    check("abc w1", 64'(got_w[1]), 64'h0);
    check("abc w15", 64'(got_w[15]), 64'h18);
    check("abc w15 flags", 64'({got_b[15], got_m[15]}), 64'h3);

    run_msg("empty", 0, 1'b1, 0, 0);
    check("empty w0", 64'(got_w[0]), 64'h80000000);
    check("empty w15", 64'(got_w[15]), 64'h0);
    check("empty msg_last", 64'(got_m[15]), 64'd1);

    for (int i = 0; i < 128; i++) msg[i] = 8'(i);
    run_msg("len55", 55, 1'b0, 0, 0);
    check("len55 w13 low byte", 64'(got_w[13][7:0]), 64'h80);
    check("len55 w13", 64'(got_w[13]), 64'h34353680);
    check("len55 w15", 64'(got_w[15]), 64'h1B8);

    run_msg("len56", 56, 1'b0, 0, 0);
    check("len56 words", 64'(got_w.size()), 64'd32);
    check("len56 blk0 w14", 64'(got_w[14]), 64'h80000000);
    check("len56 blk1 w0", 64'(got_w[16]), 64'h0);
    check("len56 blk1 w15", 64'(got_w[31]), 64'h1C0);

    run_msg("len64", 64, 1'b0, 0, 0);
    check("len64 words", 64'(got_w.size()), 64'd32);
    check("len64 w0", 64'(got_w[0]), 64'h00010203);
    check("len64 blk1 w0", 64'(got_w[16]), 64'h80000000);
    check("len64 blk1 w15", 64'(got_w[31]), 64'h200);

    for (int i = 0; i < 128; i++) msg[i] = 8'(i * 7 + 3);
    run_msg("stall", 64, 1'b0, 20, 10);

    // Abort a message while the padder is zero-filling
    load_abc();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = msg[i]; in_last = (i == 2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    run_msg("abc after abort", 3, 1'b0, 0, 0);
    check("abc2 w0", 64'(got_w[0]), 64'h61626380);
    check("abc2 w15", 64'(got_w[15]), 64'h18);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
